// File: rtl/sdram_seq.sv
`timescale 1ns/1ps
// sdram_seq: SDRAM power-up initialisation and auto-refresh sequencer that shares the command bus with a user port.
// Build option: define SDRAM_SEQ_REFLATE_EN to add the sticky REF_LATE refresh-overrun flag.
module sdram_seq #(
  parameter int          INIT_WAIT  = 20000,
  parameter int          REF_PERIOD = 780,
  parameter int          T_RP       = 2,
  parameter int          T_RFC      = 7,
  parameter int          T_MRD      = 2,
  parameter logic [12:0] MODE       = 13'h030
) (
  input  logic        CLK,
  input  logic        RSTn,
  output logic        CKE,
  output logic [3:0]  CMD,
  output logic [1:0]  BA,
  output logic [12:0] A,
  input  logic [3:0]  U_CMD,
  input  logic [1:0]  U_BA,
  input  logic [12:0] U_A,
  input  logic        U_REQ,
  output logic        U_GNT,
  output logic        READY,
  output logic        REF_PEND
`ifdef SDRAM_SEQ_REFLATE_EN
  ,
  output logic        REF_LATE
`endif
);

  typedef enum logic [2:0] {
    S_WAIT, S_PRE, S_TRP, S_REF, S_TRFC, S_MRS, S_TMRD, S_IDLE
  } state_e;

  typedef enum logic [3:0] {
    C_INHIBIT = 4'b1111,
    C_NOP     = 4'b0111,
    C_PRE     = 4'b0010,
    C_REF     = 4'b0001,
    C_MRS     = 4'b0000
  } cmd_e;

  // One shared delay counter; its width covers the longest single wait.
  localparam int CW = $clog2(INIT_WAIT + T_RP + T_RFC + T_MRD + 1);
  localparam int TW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

  state_e        state_q, state_d, after_rfc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    ref_num_q, ref_num_d;
  logic [TW-1:0] tmr_q;
  cmd_e          cmd_q, cmd_d;
  logic [12:0]   a_q, a_d;
  logic          cke_q, ready_q, ref_pend_q, pend_new_q, req_q;
  logic          expire, pre_go;
`ifdef SDRAM_SEQ_REFLATE_EN
  logic          ref_late_q;
`endif

  assign expire = ready_q && (tmr_q == TW'(REF_PERIOD - 1));

  // During init the eight refreshes chain back to back; afterwards a refresh returns to IDLE.
  always_comb begin
    if (ready_q)                after_rfc = S_IDLE;
    else if (ref_num_q == 3'd7) after_rfc = S_MRS;
    else                        after_rfc = S_REF;
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_num_d = ref_num_q;
    pre_go    = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == CW'(INIT_WAIT)) state_d = S_PRE;
        else                         cnt_d   = cnt_q + CW'(1);
      end
      S_PRE: begin
        if (T_RP > 1) begin
          state_d = S_TRP;
          cnt_d   = CW'(T_RP - 2);
        end else begin
          state_d = S_REF;
        end
      end
      S_TRP: begin
        if (cnt_q == '0) state_d = S_REF;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_REF: begin
        if (T_RFC > 1) begin
          state_d = S_TRFC;
          cnt_d   = CW'(T_RFC - 2);
        end else begin
          state_d = after_rfc;
        end
      end
      S_TRFC: begin
        if (cnt_q == '0) state_d = after_rfc;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_MRS: begin
        if (T_MRD > 1) begin
          state_d = S_TMRD;
          cnt_d   = CW'(T_MRD - 2);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TMRD: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_IDLE: begin
        // A pending refresh also wins when it appears together with a fresh U_REQ rise.
        if (ref_pend_q && (!U_REQ || (pend_new_q && !req_q))) begin
          state_d = S_PRE;
          pre_go  = 1'b1;
        end
      end
      default: state_d = S_WAIT;
    endcase
    if ((state_q == S_REF || state_q == S_TRFC) && state_d == S_REF)
      ref_num_d = ref_num_q + 3'd1;
  end

  // Sequencer bus values are decoded from the next state and registered.
  always_comb begin
    cmd_d = C_NOP;
    a_d   = '0;
    case (state_d)
      S_PRE: begin
        cmd_d   = C_PRE;
        a_d[10] = 1'b1;
      end
      S_REF: cmd_d = C_REF;
      S_MRS: begin
        cmd_d = C_MRS;
        a_d   = MODE;
      end
      default: cmd_d = C_NOP;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, and every register, counters included, has an async reset value.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= S_WAIT;
      cnt_q      <= '0;
      ref_num_q  <= '0;
      tmr_q      <= '0;
      cmd_q      <= C_INHIBIT;
      a_q        <= '0;
      cke_q      <= 1'b0;
      ready_q    <= 1'b0;
      ref_pend_q <= 1'b0;
      pend_new_q <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ref_num_q  <= ref_num_d;
      cmd_q      <= cmd_d;
      a_q        <= a_d;
      cke_q      <= 1'b1;
      ready_q    <= ready_q || (state_d == S_IDLE);
      req_q      <= U_REQ;
      pend_new_q <= expire && !ref_pend_q;
      if (ready_q) tmr_q <= expire ? '0 : tmr_q + TW'(1);
      // An expiry while a refresh is already pending is absorbed, not queued.
      if (pre_go)      ref_pend_q <= 1'b0;
      else if (expire) ref_pend_q <= 1'b1;
    end
  end

`ifdef SDRAM_SEQ_REFLATE_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                    ref_late_q <= 1'b0;
    else if (expire && ref_pend_q) ref_late_q <= 1'b1;
  end
  assign REF_LATE = ref_late_q;
`endif

  assign U_GNT    = (state_q == S_IDLE);
  assign CKE      = cke_q;
  assign CMD      = U_GNT ? U_CMD : cmd_q;
  assign BA       = U_GNT ? U_BA  : 2'b00;
  assign A        = U_GNT ? U_A   : a_q;
  assign READY    = ready_q;
  assign REF_PEND = ref_pend_q;

endmodule

// File: tb/tb_sdram_seq.sv
`timescale 1ns/1ps
// tb_sdram_seq: randomized self-checking bench for sdram_seq against a cycle-schedule reference model.
// Optionally compiled with SDRAM_SEQ_REFLATE_EN to cover REF_LATE.
module tb_sdram_seq;

  localparam int          INIT_WAIT  = 10;
  localparam int          REF_PERIOD = 50;
  localparam int          T_RP       = 2;
  localparam int          T_RFC      = 3;
  localparam int          T_MRD      = 2;
  localparam logic [12:0] MODE       = 13'h030;

  // Init schedule in cycles after reset release.
  localparam int PRE_CYC   = INIT_WAIT + 1;
  localparam int REF0_CYC  = PRE_CYC + T_RP;
  localparam int MRS_CYC   = REF0_CYC + 8 * T_RFC;
  localparam int READY_CYC = MRS_CYC + T_MRD;
  localparam int WIN       = T_RP + T_RFC;

  localparam logic [3:0] K_INH = 4'b1111;
  localparam logic [3:0] K_NOP = 4'b0111;
  localparam logic [3:0] K_PRE = 4'b0010;
  localparam logic [3:0] K_REF = 4'b0001;
  localparam logic [3:0] K_MRS = 4'b0000;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        CKE;
  logic [3:0]  CMD;
  logic [1:0]  BA;
  logic [12:0] A;
  logic [3:0]  U_CMD = 4'h7;
  logic [1:0]  U_BA = 2'b00;
  logic [12:0] U_A = 13'h0;
  logic        U_REQ = 1'b0;
  logic        U_GNT;
  logic        READY;
  logic        REF_PEND;
`ifdef SDRAM_SEQ_REFLATE_EN
  logic        REF_LATE;
`endif

  sdram_seq #(
    .INIT_WAIT (INIT_WAIT),
    .REF_PERIOD(REF_PERIOD),
    .T_RP      (T_RP),
    .T_RFC     (T_RFC),
    .T_MRD     (T_MRD),
    .MODE      (MODE)
  ) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .CKE     (CKE),
    .CMD     (CMD),
    .BA      (BA),
    .A       (A),
    .U_CMD   (U_CMD),
    .U_BA    (U_BA),
    .U_A     (U_A),
    .U_REQ   (U_REQ),
    .U_GNT   (U_GNT),
    .READY   (READY),
    .REF_PEND(REF_PEND)
`ifdef SDRAM_SEQ_REFLATE_EN
    ,
    .REF_LATE(REF_LATE)
`endif
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          pre_cyc = 0;
  int          pre_seen = 0;
  logic        have_pre = 1'b0;
  logic        m_pend = 1'b0;
  logic        m_first = 1'b0;
  logic        m_late = 1'b0;
  logic        req_hist = 1'b0;
  logic [22:0] exp_v, act_v;

  function automatic logic [3:0] init_cmd(int c);
    if (c == PRE_CYC) return K_PRE;
    if (c >= REF0_CYC && c < MRS_CYC && ((c - REF0_CYC) % T_RFC) == 0) return K_REF;
    if (c == MRS_CYC) return K_MRS;
    return K_NOP;
  endfunction

  function automatic int next_expiry(int c);
    return READY_CYC + REF_PERIOD * ((c - READY_CYC) / REF_PERIOD + 1);
  endfunction

  // Advance one clock, update the schedule model, then sample the DUT and the expectation.
  task automatic advance();
    logic r1, busy_prev, expiry;
    int   off;
    r1 = U_REQ;
    @(posedge CLK);
    #1;
    cyc++;
    if (cyc >= READY_CYC) begin
      busy_prev = have_pre && (cyc - 1 >= pre_cyc) && (cyc - 1 < pre_cyc + WIN);
      if (cyc - 1 >= READY_CYC && !busy_prev && m_pend && (!r1 || (m_first && !req_hist))) begin
        have_pre = 1'b1;
        pre_cyc  = cyc;
      end
      expiry = (cyc > READY_CYC) && (((cyc - READY_CYC) % REF_PERIOD) == 0);
      if (expiry && m_pend) m_late = 1'b1;
      m_first = expiry && !m_pend;
      if (have_pre && cyc == pre_cyc) m_pend = 1'b0;
      else if (expiry)                m_pend = 1'b1;
    end
    req_hist = r1;
    U_CMD = 4'($urandom);
    U_BA  = 2'($urandom);
    U_A   = 13'($urandom);
    #1;
    if (cyc < READY_CYC) begin
      exp_v = {1'b1, init_cmd(cyc), 2'b00,
               (cyc == PRE_CYC) ? 13'h0400 : ((cyc == MRS_CYC) ? MODE : 13'h0000),
               1'b0, 1'b0, 1'b0};
    end else if (have_pre && cyc >= pre_cyc && cyc < pre_cyc + WIN) begin
      off = cyc - pre_cyc;
      exp_v = {1'b1, (off == 0) ? K_PRE : ((off == T_RP) ? K_REF : K_NOP), 2'b00,
               (off == 0) ? 13'h0400 : 13'h0000, 1'b0, 1'b1, m_pend};
    end else begin
      exp_v = {1'b1, U_CMD, U_BA, U_A, 1'b1, 1'b1, m_pend};
    end
    act_v = {CKE, CMD, BA, A, U_GNT, READY, REF_PEND};
    if (!U_GNT && CMD === K_PRE) pre_seen++;
  endtask

  task automatic do_release();
    @(negedge CLK);
    RSTn     = 1'b1;
    U_REQ    = 1'b0;
    cyc      = 0;
    have_pre = 1'b0;
    m_pend   = 1'b0;
    m_first  = 1'b0;
    m_late   = 1'b0;
    req_hist = 1'b0;
  endtask

  task automatic check_reset_values(string tag);
    total++; if (CKE !== 1'b0)     begin bad++; $display("FAIL %s CKE got=%b want=0", tag, CKE); end
    total++; if (CMD !== K_INH)    begin bad++; $display("FAIL %s CMD got=%h want=%h", tag, CMD, K_INH); end
    total++; if (BA !== 2'b00)     begin bad++; $display("FAIL %s BA got=%h want=0", tag, BA); end
    total++; if (A !== 13'h0)      begin bad++; $display("FAIL %s A got=%h want=0", tag, A); end
    total++; if (U_GNT !== 1'b0)   begin bad++; $display("FAIL %s U_GNT got=%b want=0", tag, U_GNT); end
    total++; if (READY !== 1'b0)   begin bad++; $display("FAIL %s READY got=%b want=0", tag, READY); end
    total++; if (REF_PEND !== 1'b0) begin bad++; $display("FAIL %s REF_PEND got=%b want=0", tag, REF_PEND); end
`ifdef SDRAM_SEQ_REFLATE_EN
    total++; if (REF_LATE !== 1'b0) begin bad++; $display("FAIL %s REF_LATE got=%b want=0", tag, REF_LATE); end
`endif
  endtask

  task automatic test_reset();
    RSTn  = 1'b0;
    U_REQ = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      U_CMD = 4'($urandom);
      U_A   = 13'($urandom);
    end
    #1;
    check_reset_values("reset");
  endtask

  task automatic test_init();
    int first_ready;
    first_ready = -1;
    do_release();
    for (int c = 1; c <= READY_CYC; c++) begin
      advance();
      total++;
      if (act_v !== exp_v) begin
        bad++; $display("FAIL init cyc=%0d got=%h want=%h", cyc, act_v, exp_v);
      end
      if (first_ready < 0 && READY === 1'b1) first_ready = cyc;
    end
    total++;
    if (first_ready != READY_CYC) begin
      bad++; $display("FAIL init_ready_cycle got=%0d want=%0d", first_ready, READY_CYC);
    end
  endtask

  task automatic test_refresh_idle();
    pre_seen = 0;
    U_REQ = 1'b0;
    while (cyc < READY_CYC + REF_PERIOD + WIN + 3) begin
      advance();
      total++;
      if (act_v !== exp_v) begin
        bad++; $display("FAIL refresh_idle cyc=%0d got=%h want=%h", cyc, act_v, exp_v);
      end
      if (cyc == READY_CYC + REF_PERIOD) begin
        total++;
        if (REF_PEND !== 1'b1) begin
          bad++; $display("FAIL refresh_idle_pend cyc=%0d got=%b want=1", cyc, REF_PEND);
        end
      end
    end
    total++;
    if (pre_seen != 1) begin
      bad++; $display("FAIL refresh_idle_count got=%0d want=1", pre_seen);
    end
  endtask

  task automatic test_hold();
    int nxt, start, rel;
    nxt   = next_expiry(cyc);
    start = nxt - 9;
    rel   = nxt + int'($urandom_range(15, 25));
    pre_seen = 0;
    while (cyc < rel + WIN + 3) begin
      advance();
      total++;
      if (act_v !== exp_v) begin
        bad++; $display("FAIL hold cyc=%0d got=%h want=%h", cyc, act_v, exp_v);
      end
      if (cyc == rel) begin
        total++;
        if (pre_seen != 0) begin
          bad++; $display("FAIL hold_no_early_pre got=%0d want=0", pre_seen);
        end
      end
      U_REQ = (cyc >= start && cyc < rel);
    end
    total++;
    if (pre_seen != 1) begin
      bad++; $display("FAIL hold_count got=%0d want=1", pre_seen);
    end
  endtask

  task automatic test_race();
    int nxt;
    nxt = next_expiry(cyc);
    U_REQ = 1'b0;
    while (cyc < nxt + WIN + 3) begin
      advance();
      total++;
      if (act_v !== exp_v) begin
        bad++; $display("FAIL race cyc=%0d got=%h want=%h", cyc, act_v, exp_v);
      end
      if (cyc == nxt + 1) begin
        total++;
        if ({U_GNT, CMD} !== {1'b0, K_PRE}) begin
          bad++; $display("FAIL race_pre cyc=%0d got=%h want=%h", cyc, {U_GNT, CMD}, {1'b0, K_PRE});
        end
      end
      U_REQ = (cyc >= nxt && cyc < nxt + WIN);
    end
    U_REQ = 1'b0;
  endtask

  task automatic test_reset_mid();
    int nxt;
    nxt = next_expiry(cyc);
    U_REQ = 1'b0;
    while (cyc < nxt + 1 + T_RP + 1) begin
      advance();
      total++;
      if (act_v !== exp_v) begin
        bad++; $display("FAIL reset_mid_pre cyc=%0d got=%h want=%h", cyc, act_v, exp_v);
      end
    end
    #1;
    RSTn = 1'b0;
    #1;
    check_reset_values("reset_mid");
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_late();
    int rel;
    rel = READY_CYC + 120;
    pre_seen = 0;
    U_REQ = 1'b1;
    while (cyc < READY_CYC + 3 * REF_PERIOD + WIN + 2) begin
      advance();
      total++;
      if (act_v !== exp_v) begin
        bad++; $display("FAIL late cyc=%0d got=%h want=%h", cyc, act_v, exp_v);
      end
      if (cyc == rel + WIN + 3) begin
        total++;
        if (pre_seen != 1) begin
          bad++; $display("FAIL late_single_refresh got=%0d want=1", pre_seen);
        end
      end
      U_REQ = (cyc < rel);
    end
`ifdef SDRAM_SEQ_REFLATE_EN
    total++;
    if (REF_LATE !== m_late) begin
      bad++; $display("FAIL late_flag got=%b want=%b", REF_LATE, m_late);
    end
`endif
    total++;
    if (pre_seen != 2) begin
      bad++; $display("FAIL late_reload_refresh got=%0d want=2", pre_seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_refresh_idle();
    test_hold();
    test_race();
    test_reset_mid();
    test_init();
    test_late();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_seq.md
SDRAM_SEQ -- requirements
Module: sdram_seq

Interface
REQ-001 SHALL have parameter INIT_WAIT, default 20000, meaning power-up NOP cycles (200 us at 100 MHz).
REQ-002 SHALL have parameter REF_PERIOD, default 780, meaning cycles between auto-refresh requests (7.8 us).
REQ-003 SHALL have parameter T_RP, default 2, meaning precharge-to-command cycles (minimum 1).
REQ-004 SHALL have parameter T_RFC, default 7, meaning refresh-to-command cycles (minimum 1).
REQ-005 SHALL have parameter T_MRD, default 2, meaning mode-load-to-command cycles (minimum 1).
REQ-006 SHALL have parameter MODE, default 13'h030, meaning mode register value (CAS 3, burst 1, sequential).
REQ-007 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-008 SHALL have port RSTn, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port CKE, output, 1, SDRAM clock enable.
REQ-010 SHALL have port CMD, output, 4, {CSn,RASn,CASn,WEn}.
REQ-011 SHALL have port BA, output, 2, bank address.
REQ-012 SHALL have port A, output, 13, row/column/mode address.
REQ-013 SHALL have ports U_CMD (4), U_BA (2), U_A (13), inputs, user command bus.
REQ-014 SHALL have port U_REQ, input, 1, user holds bus; the user has all banks precharged whenever U_REQ is low.
REQ-015 SHALL have port U_GNT, output, 1, user owns the SDRAM bus.
REQ-016 SHALL have port READY, output, 1, initialization complete.
REQ-017 SHALL have port REF_PEND, output, 1, refresh due; the user releases U_REQ to allow it.

Function
REQ-018 Command encodings SHALL be: INHIBIT 1111, NOP 0111, PRECHARGE 0010 with A[10]=1, AUTO REFRESH 0001, LOAD MODE 0000.
REQ-019 Each sequencer command SHALL last one cycle and be followed by (T_x - 1) NOP cycles, where T_x is the parameter for that command.
REQ-020 States SHALL be: WAIT, PRE, TRP, REF, TRFC, MRS, TMRD, IDLE; an init flag selects the successor after TRP and TRFC.
REQ-021 Init sequence: WAIT (INIT_WAIT NOP cycles with CKE=1), PRE, TRP, then 8x (REF, TRFC), then MRS (BA=0, A=MODE), TMRD, then IDLE with READY=1.
REQ-022 In IDLE with REF_PEND=0, U_GNT SHALL be 1 and CMD/BA/A SHALL combinationally follow U_CMD/U_BA/U_A; in all other states they SHALL be driven by registered sequencer values.
REQ-023 The refresh counter SHALL start when READY rises and SHALL set REF_PEND every REF_PERIOD cycles, reloading immediately regardless of when the refresh is serviced.
REQ-024 With REF_PEND=1 and U_REQ=1, U_GNT SHALL stay 1 until U_REQ is sampled 0.
REQ-025 With REF_PEND=1 and U_REQ sampled 0 in IDLE, the next cycle SHALL have U_GNT=0 and issue PRE; TRP, a single REF and TRFC SHALL follow, then IDLE.
REQ-026 REF_PEND SHALL clear in the cycle PRE is issued.
REQ-027 If U_REQ rises in the same cycle REF_PEND is first sampled 1 while U_REQ was 0, the refresh SHALL win.
REQ-028 A counter expiry while REF_PEND=1 SHALL NOT queue a second refresh.
REQ-029 In sequencer-driven cycles, BA SHALL be 0 and A SHALL be 0 except A[10] during PRE and MODE during MRS.

Reset
REQ-030 While RSTn=0: CKE=0, CMD=INHIBIT, BA=0, A=0, U_GNT=0, READY=0, REF_PEND=0, state=WAIT, counters cleared.
REQ-031 RSTn assertion at any point, including mid-refresh, SHALL abort immediately and restart the full init sequence on release.

Configuration
REQ-032 Macro SDRAM_SEQ_REFLATE_EN defined: adds output REF_LATE (1 bit), set sticky on the REQ-028 overrun condition and cleared only by reset.
REQ-033 Macro SDRAM_SEQ_REFLATE_EN undefined: no REF_LATE port; the overrun is dropped silently.

Verification
Test parameters: INIT_WAIT=10, T_RP=2, T_RFC=3, T_MRD=2, REF_PERIOD=50.
REQ-034 Release reset -> cycles 1-10 NOP with CKE=1; cycle 11 PRE with A[10]=1; cycles 13-36 show 8 REFs spaced 3 apart; cycle 37 MRS with A=MODE; cycle 39 READY=1 and U_GNT=1.
REQ-035 U_REQ=0 idle -> REF_PEND rises 50 cycles after READY; next cycle PRE with U_GNT=0; REF 2 cycles later; U_GNT=1 3 cycles after REF.
REQ-036 U_REQ=1 held 20 cycles past REF_PEND -> U_CMD passes through unchanged until U_REQ=0; PRE follows one cycle after U_REQ is sampled 0.
REQ-037 U_REQ held 120 cycles past READY -> exactly one refresh after release; REF_LATE=1 when SDRAM_SEQ_REFLATE_EN is defined.
REQ-038 RSTn pulsed low during TRFC -> outputs return to reset values asynchronously; after release the full init repeats (cycle 39 READY=1).
REQ-039 U_REQ rises in the same cycle REF_PEND is first sampled 1 -> PRE issued and U_GNT=0 on the next cycle.
